// File: rtl/cpumem_arb.sv
// Shares the memory controller port between debug host, OAM DMA and CPU.
// Debug always wins; the DMA engine stalls the CPU while it copies a page.
module cpumem_arb #(
   parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
   parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
   parameter int          DMA_LEN       = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cpu_req,
   input  logic        cpu_wr,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_din,
   output logic        cpu_rdy,
   output logic [7:0]  cpu_dout,
   output logic        cpu_rvalid,
   input  logic        dbg_req,
   input  logic        dbg_wr,
   input  logic [15:0] dbg_addr,
   input  logic [7:0]  dbg_din,
   output logic        dbg_ack,
   output logic [7:0]  dbg_dout,
   output logic        dbg_rvalid,
   output logic        dma_busy,
   output logic        mc_wr,
   output logic [15:0] mc_addr,
   output logic [7:0]  mc_din,
   input  logic [7:0]  mc_dout
);

   localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

   typedef enum logic [1:0] {IDLE, DMA_RD, DMA_WR} state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DBG, OWN_DMA} owner_t;

   state_t     state;
   owner_t     rd_owner;
   owner_t     rd_next;
   logic [7:0] page;
   logic [7:0] idx;
   logic [7:0] dma_data;
   logic       idle;
   logic       trig;
   logic       g_dbg;
   logic       g_dma;
   logic       g_cpu;

   always_comb begin
      idle     = (state == IDLE);
      cpu_rdy  = !dbg_req && idle;
      dbg_ack  = dbg_req;
      dma_busy = !idle;
      trig     = cpu_rdy && cpu_req && cpu_wr && (cpu_addr == DMA_REG_ADDR);
      g_dbg    = rst_n && dbg_req;
      g_dma    = rst_n && !dbg_req && !idle;
      g_cpu    = rst_n && cpu_rdy && cpu_req && !trig;
      mc_wr    = 1'b0;
      mc_addr  = '0;
      mc_din   = '0;
      rd_next  = OWN_NONE;
      unique case (1'b1)
         g_dbg: begin
            mc_wr   = dbg_wr;
            mc_addr = dbg_addr;
            mc_din  = dbg_wr ? dbg_din : 8'h00;
            rd_next = dbg_wr ? OWN_NONE : OWN_DBG;
         end
         g_dma: begin
            if (state == DMA_RD) begin
               mc_addr = {page, idx};
               rd_next = OWN_DMA;
            end else begin
               // the read data lands this cycle; forward it instead of waiting
               mc_wr   = 1'b1;
               mc_addr = OAM_DATA_ADDR;
               mc_din  = (rd_owner == OWN_DMA) ? mc_dout : dma_data;
            end
         end
         g_cpu: begin
            mc_wr   = cpu_wr;
            mc_addr = cpu_addr;
            mc_din  = cpu_wr ? cpu_din : 8'h00;
            rd_next = cpu_wr ? OWN_NONE : OWN_CPU;
         end
         default: ;
      endcase
   end

   assign cpu_rvalid = (rd_owner == OWN_CPU);
   assign dbg_rvalid = (rd_owner == OWN_DBG);
   assign cpu_dout   = mc_dout;
   assign dbg_dout   = mc_dout;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         rd_owner <= OWN_NONE;
         page     <= '0;
         idx      <= '0;
         dma_data <= '0;
      end else begin
         rd_owner <= rd_next;
         if (rd_owner == OWN_DMA)
            dma_data <= mc_dout;
         if (trig) begin
            page  <= cpu_din;
            idx   <= '0;
            state <= DMA_RD;
         end else if (g_dma) begin
            if (state == DMA_RD) begin
               state <= DMA_WR;
            end else begin
               idx   <= idx + 8'd1;
               state <= (idx == LAST_IDX) ? IDLE : DMA_RD;
            end
         end
      end
   end

endmodule

// File: tb/tb_cpumem_arb.sv
// Bench for cpumem_arb: sync-read memory, transaction-level model,
// per-cycle compare plus directed scenarios with literal expectations.
module tb_cpumem_arb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cpu_req, cpu_wr;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_din;
   logic        cpu_rdy, cpu_rvalid;
   logic [7:0]  cpu_dout;
   logic        dbg_req, dbg_wr;
   logic [15:0] dbg_addr;
   logic [7:0]  dbg_din;
   logic        dbg_ack, dbg_rvalid;
   logic [7:0]  dbg_dout;
   logic        dma_busy;
   logic        mc_wr;
   logic [15:0] mc_addr;
   logic [7:0]  mc_din;
   logic [7:0]  mc_dout;

   int checks = 0;
   int errors = 0;

   logic [7:0] mem [0:65535];
   logic [7:0] ref_mem [0:65535];

   int         left = 0;
   logic [7:0] mpage = 8'h00;
   int         pown = 0;
   logic [7:0] pdata = 8'h00;

   int         oam_cnt = 0;
   int         w4014 = 0;
   int         busy_cnt = 0;
   int         rdylow = 0;
   logic [7:0] first_oam = 8'h00;
   logic [7:0] last_oam = 8'h00;

   cpumem_arb dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
      .cpu_din(cpu_din), .cpu_rdy(cpu_rdy), .cpu_dout(cpu_dout),
      .cpu_rvalid(cpu_rvalid),
      .dbg_req(dbg_req), .dbg_wr(dbg_wr), .dbg_addr(dbg_addr),
      .dbg_din(dbg_din), .dbg_ack(dbg_ack), .dbg_dout(dbg_dout),
      .dbg_rvalid(dbg_rvalid),
      .dma_busy(dma_busy),
      .mc_wr(mc_wr), .mc_addr(mc_addr), .mc_din(mc_din),
      .mc_dout(mc_dout)
   );

   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < 65536; i++) begin
         mem[i] = 8'h00;
         ref_mem[i] = 8'h00;
      end
      mc_dout = 8'h00;
   end

   // synchronous-read memory: data for a cycle-t read appears in t+1
   always @(posedge clk) begin
      mc_dout <= mem[mc_addr];
      if (mc_wr)
         mem[mc_addr] <= mc_din;
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic bus_chk(input logic wr, input logic [15:0] a,
                          input logic [7:0] d, input logic cd);
      chk("mc_wr", mc_wr, wr);
      chk("mc_addr", mc_addr, a);
      if (cd)
         chk("mc_din", mc_din, d);
   endtask

   // model: DMA is 512 un-pre-empted bus cycles alternating read/write
   always @(negedge clk) begin
      int         own_n;
      int         step;
      logic [7:0] dat_n;
      logic [15:0] a;
      if (!rst_n) begin
         left = 0;
         pown = 0;
      end
      chk("dma_busy", dma_busy, left > 0);
      chk("cpu_rdy", cpu_rdy, !dbg_req && left == 0);
      chk("dbg_ack", dbg_ack, dbg_req);
      chk("cpu_rvalid", cpu_rvalid, pown == 1);
      chk("dbg_rvalid", dbg_rvalid, pown == 2);
      if (pown == 1) chk("cpu_dout", cpu_dout, pdata);
      if (pown == 2) chk("dbg_dout", dbg_dout, pdata);
      if (rst_n && mc_wr && mc_addr == 16'h2004) begin
         if (oam_cnt == 0) first_oam = mc_din;
         last_oam = mc_din;
         oam_cnt++;
      end
      if (mc_wr && mc_addr == 16'h4014) w4014++;
      if (dma_busy) busy_cnt++;
      if (!cpu_rdy) rdylow++;
      own_n = 0;
      dat_n = 8'h00;
      if (!rst_n) begin
         chk("mc_wr_rst", mc_wr, 1'b0);
      end else if (dbg_req) begin
         bus_chk(dbg_wr, dbg_addr, dbg_din, dbg_wr);
         if (dbg_wr) ref_mem[dbg_addr] = dbg_din;
         else begin own_n = 2; dat_n = ref_mem[dbg_addr]; end
      end else if (left > 0) begin
         step = 512 - left;
         a = {mpage, 8'(step / 2)};
         if (step % 2 == 0) begin
            bus_chk(1'b0, a, 8'h00, 1'b0);
            own_n = 3;
         end else begin
            bus_chk(1'b1, 16'h2004, ref_mem[a], 1'b1);
            ref_mem[16'h2004] = ref_mem[a];
         end
         left--;
      end else if (cpu_req && cpu_wr && cpu_addr == 16'h4014) begin
         bus_chk(1'b0, 16'h0000, 8'h00, 1'b1);
         mpage = cpu_din;
         left = 512;
      end else if (cpu_req) begin
         bus_chk(cpu_wr, cpu_addr, cpu_din, cpu_wr);
         if (cpu_wr) ref_mem[cpu_addr] = cpu_din;
         else begin own_n = 1; dat_n = ref_mem[cpu_addr]; end
      end else begin
         bus_chk(1'b0, 16'h0000, 8'h00, 1'b1);
      end
      pown = own_n;
      pdata = dat_n;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_acc(input logic wr, input logic [15:0] a,
                          input logic [7:0] d);
      bit ok;
      ok = 1'b0;
      cpu_req = 1'b1; cpu_wr = wr; cpu_addr = a; cpu_din = d;
      for (int i = 0; i < 2000 && !ok; i++) begin
         @(negedge clk);
         ok = cpu_rdy;
         cyc();
      end
      cpu_req = 1'b0; cpu_wr = 1'b0;
      chk("cpu_acc_accept", ok, 1'b1);
   endtask

   task automatic dbg_acc(input logic wr, input logic [15:0] a,
                          input logic [7:0] d);
      dbg_req = 1'b1; dbg_wr = wr; dbg_addr = a; dbg_din = d;
      cyc();
      dbg_req = 1'b0; dbg_wr = 1'b0;
   endtask

   task automatic wait_idle();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 2000 && !done; i++) begin
         @(negedge clk);
         done = !dma_busy;
      end
      chk("dma_done_timeout", done, 1'b1);
      cyc();
   endtask

   task automatic clr_cnt();
      oam_cnt = 0; w4014 = 0; busy_cnt = 0; rdylow = 0;
   endtask

   initial begin
      bit seen;
      rst_n = 1'b0;
      cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_din = '0;
      dbg_req = 1'b0; dbg_wr = 1'b0; dbg_addr = '0; dbg_din = '0;
      repeat (3) cyc();
      rst_n = 1'b1;
      repeat (2) cyc();

      // 1: reset pulse in the middle of CPU read traffic
      cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 16'h0005;
      repeat (3) cyc();
      rst_n = 1'b0;
      #1;
      chk("t1_mc_wr", mc_wr, 1'b0);
      chk("t1_busy", dma_busy, 1'b0);
      chk("t1_cpu_rvalid", cpu_rvalid, 1'b0);
      chk("t1_dbg_rvalid", dbg_rvalid, 1'b0);
      chk("t1_cpu_rdy", cpu_rdy, 1'b1);
      cyc();
      cpu_req = 1'b0;
      rst_n = 1'b1;
      cyc();

      // 2: CPU write then read back
      clr_cnt();
      cpu_acc(1'b1, 16'h0005, 8'hA5);
      cpu_acc(1'b0, 16'h0005, 8'h00);
      @(negedge clk);
      chk("t2_rvalid", cpu_rvalid, 1'b1);
      chk("t2_dout", cpu_dout, 8'hA5);
      cyc();

      // 3: preload page 2, then uncontested DMA
      for (int i = 0; i < 256; i++)
         dbg_acc(1'b1, 16'h0200 + 16'(i), 8'(i) ^ 8'h5A);
      cyc();
      clr_cnt();
      cpu_acc(1'b1, 16'h4014, 8'h02);
      wait_idle();
      chk("t3_oam_cnt", oam_cnt, 256);
      chk("t3_first", first_oam, 8'h5A);
      chk("t3_last", last_oam, 8'hA5);
      chk("t3_w4014", w4014, 0);
      chk("t3_busy_cycles", busy_cnt, 512);
      chk("t3_rdy_low", rdylow, 512);
      chk("t3_rdy_after", cpu_rdy, 1'b1);

      // 4: debug and CPU collide in idle
      dbg_req = 1'b1; dbg_wr = 1'b0; dbg_addr = 16'h0010;
      cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 16'h0011; cpu_din = 8'h3C;
      @(negedge clk);
      chk("t4_rdy_low", cpu_rdy, 1'b0);
      chk("t4_dbg_addr", mc_addr, 16'h0010);
      cyc();
      dbg_req = 1'b0;
      @(negedge clk);
      chk("t4_rdy", cpu_rdy, 1'b1);
      chk("t4_cpu_wr", mc_wr, 1'b1);
      chk("t4_cpu_addr", mc_addr, 16'h0011);
      chk("t4_dbg_rvalid", dbg_rvalid, 1'b1);
      chk("t4_dbg_dout", dbg_dout, 8'h00);
      cyc();
      cpu_req = 1'b0; cpu_wr = 1'b0;
      cyc();

      // 5: debug pre-empts the DMA write of byte 0x10 for 3 cycles
      clr_cnt();
      cpu_acc(1'b1, 16'h4014, 8'h02);
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         seen = dma_busy && !mc_wr && mc_addr == 16'h0210;
      end
      chk("t5_seen_rd", seen, 1'b1);
      cyc();
      dbg_req = 1'b1; dbg_wr = 1'b0; dbg_addr = 16'h0300;
      repeat (3) cyc();
      dbg_req = 1'b0;
      wait_idle();
      chk("t5_oam_cnt", oam_cnt, 256);
      chk("t5_busy_cycles", busy_cnt, 515);
      chk("t5_rdy_low", rdylow, 515);

      // 6: reset in the middle of a DMA (at idx 0x80)
      clr_cnt();
      cpu_acc(1'b1, 16'h4014, 8'h02);
      seen = 1'b0;
      for (int i = 0; i < 600 && !seen; i++) begin
         @(negedge clk);
         seen = mc_wr && mc_addr == 16'h2004 && mc_din == 8'h25;
      end
      chk("t6_seen_7f", seen, 1'b1);
      cyc();
      rst_n = 1'b0;
      #1;
      chk("t6_busy_async", dma_busy, 1'b0);
      chk("t6_mc_wr", mc_wr, 1'b0);
      repeat (2) cyc();
      rst_n = 1'b1;
      repeat (600) cyc();
      chk("t6_oam_cnt", oam_cnt, 128);
      chk("t6_busy", dma_busy, 1'b0);
      chk("t6_rdy", cpu_rdy, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/cpumem_arb.md
Name: cpumem_arb

Overview:
Arbiter and sequencer for the CPU memory controller port, with a single address/write/data bus and a synchronous-read memory. It shares that port between the CPU, a debug host, and an internal sprite OAM DMA engine. A CPU write to the DMA register triggers the engine, which copies 256 bytes from page N to the OAM data register while the CPU is stalled.

Parameters:
DMA_REG_ADDR, 16'h4014, CPU write address that triggers OAM DMA
OAM_DATA_ADDR, 16'h2004, destination address for every DMA write
DMA_LEN, 256, bytes per DMA transfer (page size; index width 8)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
cpu_req  input  1  CPU access request this cycle
cpu_wr  input  1  CPU access is write
cpu_addr  input  16  CPU address
cpu_din  input  8  CPU write data
cpu_rdy  output  1  CPU access accepted this cycle; CPU must hold request when 0
cpu_dout  output  8  CPU read data
cpu_rvalid  output  1  cpu_dout valid (cycle after accepted read)
dbg_req  input  1  debug access request
dbg_wr  input  1  debug access is write
dbg_addr  input  16  debug address
dbg_din  input  8  debug write data
dbg_ack  output  1  debug access issued this cycle
dbg_dout  output  8  debug read data
dbg_rvalid  output  1  dbg_dout valid
dma_busy  output  1  OAM DMA in progress
mc_wr  output  1  memory controller write enable
mc_addr  output  16  memory controller address
mc_din  output  8  memory controller write data
mc_dout  input  8  memory controller read data

Behaviour:
- Clock is clk; reset is rst_n, asynchronous, active-low.
- Memory contract: a read issued in cycle t presents its data on mc_dout in cycle t+1, regardless of the mc_addr value in t+1.
- One access per cycle. Fixed priority: debug > DMA > CPU.
- Debug access:
  - dbg_ack = dbg_req. Debug is always granted.
  - A debug write to DMA_REG_ADDR is forwarded to memory and does not trigger DMA.
- CPU access:
  - cpu_rdy = !dbg_req && state==IDLE.
  - An accepted CPU write to DMA_REG_ADDR is not forwarded (mc_wr=0 that cycle).
  - That write latches page=cpu_din and idx=0. The state becomes DMA_RD on the next edge.
- FSM IDLE / DMA_RD / DMA_WR:
  - DMA_RD: if not pre-empted, issue read at {page,idx}. Next state is DMA_WR.
  - DMA_WR: if not pre-empted, issue write with mc_addr=OAM_DATA_ADDR and mc_din=dma_data. Then increment idx.
  - After the write at idx=DMA_LEN-1, go to IDLE (idx wraps to 0). Otherwise go to DMA_RD.
  - Pre-empted (dbg_req=1): the state, idx and dma_data are held. The step retries in the next cycle.
- Read-data routing:
  - Register rd_owner ∈ {NONE, CPU, DBG, DMA} at each issued read.
  - In the following cycle:
    - cpu_rvalid=(rd_owner==CPU).
    - dbg_rvalid=(rd_owner==DBG).
    - cpu_dout and dbg_dout are driven from mc_dout.
    - If rd_owner==DMA, dma_data<=mc_dout.
- Idle bus (no grant): mc_wr=0, mc_addr=0, mc_din=0, rd_owner<=NONE.
- dma_busy = (state != IDLE).
- Uncontested DMA takes exactly 2×DMA_LEN cycles. cpu_rdy is 0 from the cycle after the trigger through the last DMA write, then returns to 1.
- Reset (async, any time including mid-DMA):
  - State and registers: state=IDLE, idx=0, page=0, dma_data=0, rd_owner=NONE.
  - Outputs: mc_wr=0, dma_busy=0, cpu_rvalid=0, dbg_rvalid=0. cpu_rdy=1 when dbg_req=0.
  - No further OAM writes after a reset mid-DMA.

Test Plan:
1. Pulse rst_n low mid-traffic -> mc_wr=0, dma_busy=0, cpu_rvalid=dbg_rvalid=0, cpu_rdy=1 immediately.
2. CPU write 0x0005←0xA5, then read 0x0005 -> one mc_wr pulse at addr 0x0005 with din 0xA5; read gives cpu_rvalid=1 and cpu_dout=0xA5 on the next cycle.
3. Preload 0x0200+i = i^0x5A, then CPU writes 0x4014←0x02 -> no mc write to 0x4014; 256 writes to 0x2004 with data i^0x5A in order; cpu_rdy=0 and dma_busy=1 for exactly 512 cycles.
4. dbg_req and cpu_req in the same IDLE cycle (dbg read 0x0010, cpu write 0x0011) -> dbg issued and cpu_rdy=0 in that cycle; the CPU write is issued the next cycle; dbg_rvalid follows the dbg read.
5. dbg_req held 3 cycles while the FSM is in DMA_WR for idx 0x10 -> DMA stalls 3 cycles; byte 0x10 is still written correctly; total DMA duration is 515 cycles.
6. rst_n asserted during DMA at idx 0x80 -> dma_busy=0 asynchronously; no further 0x2004 writes; cpu_rdy=1 after release.
